// File: rtl/accum_dump_if.sv
// Sample-in / result-out handshake bundle for the block accumulator.
interface accum_dump_if #(
    parameter int NN = 16,
    parameter int OW = 24
) ();
    logic          in_valid;
    logic          in_ready;
    logic [NN-1:0] in_data;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_sat;

    modport master (
        output in_valid, in_data, clear, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, clear, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/accum_dump.sv
// Block accumulator: sums LEN signed samples, applies an arithmetic right
// shift, saturates the result to OW bits and holds it in a one-entry
// valid/ready output register. A new block starts immediately after each dump.
module accum_dump #(
    parameter int NN    = 16,
    parameter int OW    = 24,
    parameter int LEN   = 8,
    parameter int SHIFT = 0
) (
    input  logic         clk,
    input  logic         reset,
    accum_dump_if.slave  bus
);
    localparam int CW  = $clog2(LEN);
    localparam int ACC = NN + CW;
    localparam int EW  = (ACC > OW) ? ACC : OW;

    localparam logic [CW-1:0]        LAST = CW'(LEN - 1);
    localparam logic signed [EW-1:0] MAXV = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic [CW-1:0]         cnt;
    logic signed [ACC-1:0] acc;
    logic signed [ACC-1:0] sum;
    logic signed [ACC-1:0] scaled;
    logic signed [EW-1:0]  wide;
    logic [OW-1:0]         sat_data;
    logic                  sat_flag;
    logic                  last;
    logic                  accept;
    logic                  load;

    // Handshake: only the block-completing sample stalls behind a pending result.
    always_comb begin
        last         = (cnt == LAST);
        bus.in_ready = !bus.clear && !(last && bus.out_valid && !bus.out_ready);
        accept       = bus.in_valid && bus.in_ready;
        load         = accept && last;
    end

    // Running sum, floor-shift and clamp of the completed block.
    always_comb begin
        sum      = acc + ACC'($signed(bus.in_data));
        scaled   = sum >>> SHIFT;
        wide     = EW'(scaled);
        sat_data = wide[OW-1:0];
        sat_flag = 1'b0;
        if (wide > MAXV) begin
            sat_data = MAXV[OW-1:0];
            sat_flag = 1'b1;
        end else if (wide < MINV) begin
            sat_data = MINV[OW-1:0];
            sat_flag = 1'b1;
        end
    end

    // Accumulator and sample counter; restart from zero on completion or clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (bus.clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Output register: a load wins over a simultaneous consume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= sat_data;
            bus.out_sat   <= sat_flag;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_accum_dump.sv
// Directed bench for accum_dump: dut_a (LEN=4, SHIFT=0) and dut_b (LEN=4, SHIFT=2).
module tb_accum_dump;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    accum_dump_if #(.NN(16), .OW(16)) ifa ();
    accum_dump_if #(.NN(16), .OW(16)) ifb ();

    accum_dump #(.NN(16), .OW(16), .LEN(4), .SHIFT(0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    accum_dump #(.NN(16), .OW(16), .LEN(4), .SHIFT(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample on dut_a, optionally check in_ready, then clock it.
    task automatic send_a(input logic [15:0] d, input string tag, input logic exp_rdy);
        ifa.in_valid = 1'b1;
        ifa.in_data  = d;
        #1;
        chk(tag, {31'b0, ifa.in_ready}, {31'b0, exp_rdy});
        tick();
    endtask

    task automatic send_b(input logic [15:0] d);
        ifb.in_valid = 1'b1;
        ifb.in_data  = d;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.clear = 1'b0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.clear = 1'b0; ifb.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, ifa.out_valid}, 0);
        chk("rst_data",  $signed(ifa.out_data), 0);
        chk("rst_sat",   {31'b0, ifa.out_sat}, 0);
        chk("rst_ready", {31'b0, ifa.in_ready}, 1);
        chk("rst_valid_b", {31'b0, ifb.out_valid}, 0);
        reset = 1'b0;
        tick();

        // Basic dump and back-to-back continuation
        ifa.out_ready = 1'b1;
        send_a(16'd1, "b_rdy1", 1'b1);
        send_a(16'd2, "b_rdy2", 1'b1);
        send_a(16'd3, "b_rdy3", 1'b1);
        chk("basic_not_yet", {31'b0, ifa.out_valid}, 0);
        send_a(16'd4, "b_rdy4", 1'b1);
        chk("basic_valid", {31'b0, ifa.out_valid}, 1);
        chk("basic_data",  $signed(ifa.out_data), 10);
        chk("basic_sat",   {31'b0, ifa.out_sat}, 0);
        send_a(16'd5, "b_rdy5", 1'b1);
        chk("basic_one_cycle", {31'b0, ifa.out_valid}, 0);
        send_a(16'd6, "b_rdy6", 1'b1);
        send_a(16'd7, "b_rdy7", 1'b1);
        send_a(16'd8, "b_rdy8", 1'b1);
        chk("stream_valid", {31'b0, ifa.out_valid}, 1);
        chk("stream_data",  $signed(ifa.out_data), 26);

        // Saturation
        repeat (4) send_a(16'h7FFF, "sat_rdy", 1'b1);
        chk("satpos_data", $signed(ifa.out_data), 32767);
        chk("satpos_sat",  {31'b0, ifa.out_sat}, 1);
        repeat (4) send_a(16'h8000, "sat_rdy", 1'b1);
        chk("satneg_data", $signed(ifa.out_data), -32768);
        chk("satneg_sat",  {31'b0, ifa.out_sat}, 1);
        repeat (4) send_a(16'h2000, "sat_rdy", 1'b1);
        chk("satedge_data", $signed(ifa.out_data), 32767);
        chk("satedge_sat",  {31'b0, ifa.out_sat}, 1);
        ifa.in_valid = 1'b0;
        tick();
        chk("idle_valid", {31'b0, ifa.out_valid}, 0);

        // Backpressure
        ifa.out_ready = 1'b0;
        send_a(16'd1, "bp_rdy1", 1'b1);
        send_a(16'd2, "bp_rdy2", 1'b1);
        send_a(16'd3, "bp_rdy3", 1'b1);
        send_a(16'd4, "bp_rdy4", 1'b1);
        chk("bp_first", $signed(ifa.out_data), 10);
        send_a(16'd1, "bp_rdy5", 1'b1);
        send_a(16'd1, "bp_rdy6", 1'b1);
        send_a(16'd1, "bp_rdy7", 1'b1);
        send_a(16'd1, "bp_stall", 1'b0);
        tick();
        chk("bp_hold_valid", {31'b0, ifa.out_valid}, 1);
        chk("bp_hold_data",  $signed(ifa.out_data), 10);
        ifa.out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", {31'b0, ifa.in_ready}, 1);
        tick();
        chk("bp_new_valid", {31'b0, ifa.out_valid}, 1);
        chk("bp_new_data",  $signed(ifa.out_data), 4);
        ifa.in_valid = 1'b0;
        tick();
        chk("bp_drained", {31'b0, ifa.out_valid}, 0);

        // Clear
        send_a(16'd7, "clr_rdy1", 1'b1);
        send_a(16'd7, "clr_rdy2", 1'b1);
        ifa.clear = 1'b1;
        send_a(16'd9, "clr_ready", 1'b0);
        ifa.clear = 1'b0;
        send_a(16'd5, "clr_rdy3", 1'b1);
        send_a(16'd5, "clr_rdy4", 1'b1);
        send_a(16'd5, "clr_rdy5", 1'b1);
        chk("clr_not_yet", {31'b0, ifa.out_valid}, 0);
        send_a(16'd5, "clr_rdy6", 1'b1);
        chk("clr_valid", {31'b0, ifa.out_valid}, 1);
        chk("clr_data",  $signed(ifa.out_data), 20);
        ifa.in_valid = 1'b0;
        tick();

        // Shift and floor on dut_b
        ifb.out_ready = 1'b1;
        send_b(-16'sd1);
        send_b(-16'sd2);
        send_b(-16'sd3);
        send_b(-16'sd4);
        chk("shift_neg_valid", {31'b0, ifb.out_valid}, 1);
        chk("shift_neg_data",  $signed(ifb.out_data), -3);
        send_b(16'd1);
        send_b(16'd2);
        send_b(16'd3);
        send_b(16'd4);
        chk("shift_pos_data", $signed(ifb.out_data), 2);
        chk("shift_pos_sat",  {31'b0, ifb.out_sat}, 0);
        ifb.in_valid = 1'b0;
        tick();

        // Asynchronous reset with partial sum and pending result
        ifa.out_ready = 1'b0;
        send_a(16'd1, "ar_rdy1", 1'b1);
        send_a(16'd2, "ar_rdy2", 1'b1);
        send_a(16'd3, "ar_rdy3", 1'b1);
        send_a(16'd4, "ar_rdy4", 1'b1);
        send_a(16'd1, "ar_rdy5", 1'b1);
        send_a(16'd1, "ar_rdy6", 1'b1);
        chk("ar_pending", {31'b0, ifa.out_valid}, 1);
        ifa.in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("ar_valid", {31'b0, ifa.out_valid}, 0);
        chk("ar_data",  $signed(ifa.out_data), 0);
        chk("ar_sat",   {31'b0, ifa.out_sat}, 0);
        tick();
        reset = 1'b0;
        ifa.out_ready = 1'b1;
        send_a(16'd1, "ar_rdy7", 1'b1);
        send_a(16'd1, "ar_rdy8", 1'b1);
        send_a(16'd1, "ar_rdy9", 1'b1);
        chk("ar_not_yet", {31'b0, ifa.out_valid}, 0);
        send_a(16'd1, "ar_rdy10", 1'b1);
        chk("ar_after_valid", {31'b0, ifa.out_valid}, 1);
        chk("ar_after_data",  $signed(ifa.out_data), 4);
        ifa.in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/accum_dump.md
# accum_dump

Block-accumulate stage that consumes the registered product stream from the multiplier pipeline flops. It sums exactly LEN accepted signed samples, scales the sum by an arithmetic right shift, saturates it to OW bits, and presents the result on a single-entry valid/ready output register. Between dumps it restarts from zero with no dead cycles.

## Interface
- NN, 16: input sample width, signed two's complement.
- OW, 24: output width, signed.
- LEN, 8: samples per dump, ≥2.
- SHIFT, 0: arithmetic right shift applied to the sum before saturation, 0..NN.
- Internal accumulator width ACC = NN + clog2(LEN). This is derived, not a parameter, so the accumulator never wraps.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts in_data this cycle. Combinational.
- in_data  in  NN  signed sample.
- clear  in  1  synchronous discard of the partial accumulation.
- out_valid  out  1  out_data/out_sat hold an unconsumed result.
- out_ready  in  1  downstream consumes the result this cycle.
- out_data  out  OW  signed scaled, saturated sum.
- out_sat  out  1  out_data was clamped.

## Operation
- Reset value of every output: out_valid=0, out_data=0, out_sat=0. Internal acc=0 and cnt=0.
- Accept: a sample is accepted when in_valid && in_ready.
- Partial update: an accepted sample with cnt<LEN-1 does acc ← acc + sext(in_data) and cnt ← cnt+1.
- Completion: the accepted sample with cnt==LEN-1 forms sum = acc + sext(in_data). Then acc ← 0, cnt ← 0, and the output register is loaded.
- Output load: s = sum >>> SHIFT, an arithmetic shift rounding toward −∞.
  - If s > 2^(OW-1)−1: out_data = 2^(OW-1)−1, out_sat=1.
  - If s < −2^(OW-1): out_data = −2^(OW-1), out_sat=1.
  - Otherwise: out_data = s[OW-1:0], out_sat=0.
  - out_valid ← 1.
- Consume: out_valid && out_ready with no simultaneous load clears out_valid. out_data and out_sat keep their last values.
- Backpressure: in_ready = !clear && !(cnt==LEN-1 && out_valid && !out_ready).
  - Partial samples are always accepted while a result is pending.
  - Only the completing sample stalls.
- Simultaneous consume and load: the new result replaces the old one and out_valid stays 1.
- clear:
  - acc ← 0 and cnt ← 0 at the next edge.
  - in_ready=0 that cycle, so a sample presented with clear is not accepted.
  - A pending output result is unaffected.
- Reset mid-accumulation or with a pending output: all state returns to reset values immediately. Partial sums and the pending result are lost.

## Timing
- Latency: out_valid rises at the same posedge that accepts the LEN-th sample, so the result is visible one cycle after that sample is presented.
- Throughput: one sample per cycle. Back-to-back dumps every LEN cycles when out_ready is held high.
- out_valid, out_data and out_sat are registered, with no combinational path from inputs.
- in_ready depends combinationally on out_ready, out_valid, cnt and clear.
- Holding: once out_valid=1, out_data and out_sat stay stable until the consuming edge.

## Test plan
- Basic dump (NN=16, OW=16, LEN=4, SHIFT=0):
  - Stimulus: in_data 1,2,3,4 on consecutive cycles, out_ready=1.
  - Required: out_valid=1 for one cycle with out_data=10 and out_sat=0, starting one cycle after sample 4.
  - Then a continued stream 5,6,7,8 → out_data=26 with no gap cycle.
- Saturation (same config):
  - 4× 0x7FFF → out_data=32767, out_sat=1.
  - 4× 0x8000 → out_data=−32768, out_sat=1.
  - 4× 0x2000 (sum 32768) → 32767, out_sat=1.
- Backpressure (same config):
  - Stimulus: out_ready=0, in_valid held high with 1,2,3,4,1,1,1,1.
  - Required: first result 10 is held. Samples 5–7 are accepted. in_ready=0 while the 8th sample waits.
  - Raise out_ready for one cycle → 10 is consumed and the 8th sample is accepted in the same cycle; next cycle out_data=4.
- Clear (same config):
  - Stimulus: accept 7,7; then clear=1 with in_valid=1 and in_data=9.
  - Required: in_ready=0 during clear.
  - Then 5,5,5,5 → out_data=20.
- Shift and floor (LEN=4, SHIFT=2):
  - Samples −1,−2,−3,−4 (sum −10) → out_data=−3.
  - Samples 1,2,3,4 → out_data=2.
- Asynchronous reset:
  - Stimulus: assert reset mid-cycle after 2 accepted samples with a pending result.
  - Required: out_valid, out_data and out_sat go to 0 without waiting for a clock edge.
  - After release, 1,1,1,1 → out_data=4.
